// File: rtl/spi_reg_pkg.sv
// Shared encodings for the SPI register decoder: FSM state codes and command-byte bit positions.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_CHECK = 2'd2,
        ST_SKIP  = 2'd3
    } state_t;

    localparam int CMD_WR_BIT  = 7;
    localparam int CMD_RSV_BIT = 6;

endpackage

// File: rtl/spi_rdy_sync.sv
// Two-flop synchroniser for a slow asynchronous flag. With EDGE=1 the output is a
// one-cycle pulse on a rising edge of the synchronised value; with EDGE=0 it is the level.
module spi_rdy_sync #(
    parameter bit EDGE = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_out
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Metastability filter followed by a delay flop for edge detection
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_out = EDGE ? (r_sync & ~r_prev) : r_sync;

endmodule

// File: rtl/spi_reg_decoder.sv
// SPI command decoder: turns byte frames (command byte + write data) from the SPI byte
// receiver into writes on a bank of NREGS registers.
// Optional feature macro SPI_REG_CHECKSUM_EN: every data byte must be followed by a check
// byte equal to data ^ command; mismatches are rejected and the frame is skipped.
module spi_reg_decoder
    import spi_reg_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int NREGS     = 4,
    parameter int ADDRW     = $clog2(NREGS)
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [DATAWIDTH-1:0]       i_spi_data,
    input  logic                       i_spi_data_rdy,
    input  logic                       i_spi_nsel,
    output logic [NREGS*DATAWIDTH-1:0] o_reg_out,
    output logic                       o_wr_strobe,
    output logic [ADDRW-1:0]           o_wr_addr,
    output logic                       o_frame_err
);

    localparam logic [ADDRW-1:0] ADDR_LAST = ADDRW'(NREGS - 1);

    logic                 w_byte_ev;
    logic                 w_nsel_s;
    logic [ADDRW-1:0]     w_cmd_addr;
    logic                 w_cmd_bad;

    state_t                              r_state;
    logic [ADDRW-1:0]                    r_addr;
    logic [NREGS-1:0][DATAWIDTH-1:0]     r_bank;
    logic                                r_wr_strobe;
    logic [ADDRW-1:0]                    r_wr_addr;
    logic                                r_frame_err;
`ifdef SPI_REG_CHECKSUM_EN
    logic [DATAWIDTH-1:0]                r_cmd;
    logic [DATAWIDTH-1:0]                r_stage;
`endif

    spi_rdy_sync #(.EDGE(1'b1)) u_rdy_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_spi_data_rdy),
        .o_out   (w_byte_ev)
    );

    spi_rdy_sync #(.EDGE(1'b0)) u_nsel_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_spi_nsel),
        .o_out   (w_nsel_s)
    );

    // Start address lives in the low command bits; out-of-range only possible for non-power-of-2 NREGS
    assign w_cmd_addr = i_spi_data[ADDRW-1:0];
    assign w_cmd_bad  = i_spi_data[CMD_RSV_BIT] || (32'(w_cmd_addr) >= 32'(NREGS));

    // Frame parser, address counter and register bank; chip-select release wins over a byte
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_bank      <= '0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_frame_err <= 1'b0;
`ifdef SPI_REG_CHECKSUM_EN
            r_cmd       <= '0;
            r_stage     <= '0;
`endif
        end else begin
            r_wr_strobe <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_nsel_s) begin
                r_state <= ST_IDLE;
            end else if (w_byte_ev) begin
                case (r_state)
                    ST_IDLE: begin
                        // bit7 clear is a NOP command: stay idle, no error
                        if (i_spi_data[CMD_WR_BIT]) begin
                            if (w_cmd_bad) begin
                                r_state     <= ST_SKIP;
                                r_frame_err <= 1'b1;
                            end else begin
                                r_state <= ST_DATA;
                                r_addr  <= w_cmd_addr;
`ifdef SPI_REG_CHECKSUM_EN
                                r_cmd   <= i_spi_data;
`endif
                            end
                        end
                    end
                    ST_DATA: begin
`ifdef SPI_REG_CHECKSUM_EN
                        r_stage <= i_spi_data;
                        r_state <= ST_CHECK;
`else
                        r_bank[r_addr] <= i_spi_data;
                        r_wr_strobe    <= 1'b1;
                        r_wr_addr      <= r_addr;
                        r_addr         <= (r_addr == ADDR_LAST) ? '0 : r_addr + 1'b1;
`endif
                    end
                    ST_CHECK: begin
`ifdef SPI_REG_CHECKSUM_EN
                        if (i_spi_data == (r_stage ^ r_cmd)) begin
                            r_bank[r_addr] <= r_stage;
                            r_wr_strobe    <= 1'b1;
                            r_wr_addr      <= r_addr;
                            r_addr         <= (r_addr == ADDR_LAST) ? '0 : r_addr + 1'b1;
                            r_state        <= ST_DATA;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_SKIP;
                        end
`else
                        r_state <= ST_IDLE;
`endif
                    end
                    default: begin
                        // SKIP: discard bytes until chip select is released
                        r_state <= ST_SKIP;
                    end
                endcase
            end
        end
    end

    assign o_reg_out   = r_bank;
    assign o_wr_strobe = r_wr_strobe;
    assign o_wr_addr   = r_wr_addr;
    assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_reg_decoder.sv
// Directed bench for spi_reg_decoder (DATAWIDTH=8, NREGS=4). Also covers the
// SPI_REG_CHECKSUM_EN build when that macro is defined.
module tb_spi_reg_decoder;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [7:0]  i_spi_data = 8'h00;
    logic        i_spi_data_rdy = 1'b0;
    logic        i_spi_nsel = 1'b1;
    logic [31:0] o_reg_out;
    logic        o_wr_strobe;
    logic [1:0]  o_wr_addr;
    logic        o_frame_err;

    int checks = 0;
    int failures = 0;
    int n_strobe = 0;
    int n_err = 0;
    int s0;
    int e0;

    spi_reg_decoder #(.DATAWIDTH(8), .NREGS(4)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_spi_data     (i_spi_data),
        .i_spi_data_rdy (i_spi_data_rdy),
        .i_spi_nsel     (i_spi_nsel),
        .o_reg_out      (o_reg_out),
        .o_wr_strobe    (o_wr_strobe),
        .o_wr_addr      (o_wr_addr),
        .o_frame_err    (o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    // Pulse counters sampled on the inactive edge
    always @(negedge i_clk) begin
        if (o_wr_strobe) n_strobe++;
        if (o_frame_err) n_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge i_clk);
        i_spi_data = b;
        i_spi_data_rdy = 1'b1;
        repeat (4) @(negedge i_clk);
        i_spi_data_rdy = 1'b0;
        repeat (4) @(negedge i_clk);
    endtask

    // Byte whose commit timing is checked: strobe must appear on the 3rd clk after rdy rises
    task automatic send_timed(input logic [7:0] b, input logic [1:0] addr);
        @(negedge i_clk);
        i_spi_data = b;
        i_spi_data_rdy = 1'b1;
        @(posedge i_clk);
        @(posedge i_clk);
        #1 check("strobe_not_early", {31'd0, o_wr_strobe}, 32'd0);
        @(posedge i_clk);
        #1 check("strobe_at_3clk", {31'd0, o_wr_strobe}, 32'd1);
        check("wr_addr_at_3clk", {30'd0, o_wr_addr}, {30'd0, addr});
        repeat (2) @(negedge i_clk);
        i_spi_data_rdy = 1'b0;
        repeat (4) @(negedge i_clk);
    endtask

    // One data byte, plus its check byte in the checksum build
    task automatic send_data(input logic [7:0] cmd, input logic [7:0] b);
        send_byte(b);
`ifdef SPI_REG_CHECKSUM_EN
        send_byte(b ^ cmd);
`else
        if (cmd == 8'hFF) $display("note: unused cmd");
`endif
    endtask

    task automatic frame_gap();
        @(negedge i_clk);
        i_spi_nsel = 1'b1;
        repeat (4) @(negedge i_clk);
        i_spi_nsel = 1'b0;
        repeat (4) @(negedge i_clk);
    endtask

    initial begin
        // Power-on reset
        #2;
        check("rst_reg_out", o_reg_out, 32'h0);
        check("rst_strobe", {31'd0, o_wr_strobe}, 32'd0);
        check("rst_wr_addr", {30'd0, o_wr_addr}, 32'd0);
        check("rst_frame_err", {31'd0, o_frame_err}, 32'd0);
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        frame_gap();

        // Single write with latency check
        s0 = n_strobe;
        send_byte(8'h81);
`ifdef SPI_REG_CHECKSUM_EN
        send_byte(8'hA5);
        send_timed(8'hA5 ^ 8'h81, 2'd1);
`else
        send_timed(8'hA5, 2'd1);
`endif
        check("write_reg1", o_reg_out, 32'h0000A500);
        check("write_strobes", n_strobe - s0, 32'd1);

        // Burst from address 3 wraps to 0
        frame_gap();
        s0 = n_strobe;
        send_byte(8'h83);
        send_data(8'h83, 8'h11);
        send_data(8'h83, 8'h22);
        send_data(8'h83, 8'h33);
        check("burst_wrap_regs", o_reg_out, 32'h11003322);
        check("burst_strobes", n_strobe - s0, 32'd3);
        check("burst_last_addr", {30'd0, o_wr_addr}, 32'd1);

        // Reserved bit set: error, rest of frame skipped
        frame_gap();
        s0 = n_strobe;
        e0 = n_err;
        send_byte(8'hC0);
        send_byte(8'h55);
        send_byte(8'h55);
        check("badcmd_err", n_err - e0, 32'd1);
        check("badcmd_no_write", n_strobe - s0, 32'd0);
        check("badcmd_regs", o_reg_out, 32'h11003322);
        frame_gap();
        send_byte(8'h80);
        send_data(8'h80, 8'h77);
        check("after_skip_reg0", o_reg_out, 32'h11003377);

        // NOP command, then a fresh frame
        frame_gap();
        s0 = n_strobe;
        e0 = n_err;
        send_byte(8'h02);
        check("nop_no_write", n_strobe - s0, 32'd0);
        check("nop_no_err", n_err - e0, 32'd0);
        frame_gap();
        send_byte(8'h82);
        send_data(8'h82, 8'h3C);
        check("after_nop_reg2", o_reg_out, 32'h113C3377);

        // Don't-care command bits ignored: 0xBD -> write, addr 1
        frame_gap();
        send_byte(8'hBD);
        send_data(8'hBD, 8'h99);
        check("ignored_bits_reg1", o_reg_out, 32'h113C9977);

        // Asynchronous reset mid-burst
        frame_gap();
        send_byte(8'h80);
        send_data(8'h80, 8'h12);
        check("preburst_reg0", o_reg_out, 32'h113C9912);
        @(negedge i_clk);
        #2 i_reset = 1'b1;
        #1;
        check("async_rst_regs", o_reg_out, 32'h0);
        check("async_rst_wr_addr", {30'd0, o_wr_addr}, 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        s0 = n_strobe;
        send_byte(8'h34);
        check("post_rst_idle_nop", n_strobe - s0, 32'd0);
        check("post_rst_regs", o_reg_out, 32'h0);

`ifdef SPI_REG_CHECKSUM_EN
        frame_gap();
        send_byte(8'h80);
        send_byte(8'h5A);
        send_byte(8'hDA);
        check("cksum_ok_reg0", o_reg_out, 32'h0000005A);
        frame_gap();
        s0 = n_strobe;
        e0 = n_err;
        send_byte(8'h80);
        send_byte(8'h5A);
        send_byte(8'h00);
        check("cksum_bad_err", n_err - e0, 32'd1);
        check("cksum_bad_no_write", n_strobe - s0, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
